// File: rtl/pong_pkg.sv
// Shared definitions for the pong hit judge: FSM state encoding, default
// sizing parameters and the serve/winner direction constants.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RALLY = 2'd1,
        SERVE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned WIN_SCORE_DEF = 7;
    localparam int unsigned LED_W_DEF     = 8;
    localparam int unsigned SCORE_W       = 4;

    // Direction / player identity: 0 = left, 1 = right.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pong_hit_judge_if.sv
// Signal bundle between the pong game fabric and the hit judge.
//   master : the surrounding fabric (clock divider, pattern generator,
//            button synchronizers, score display) - drives Tick, Ball,
//            BtnL, BtnR, Begin and observes the judge outputs.
//   slave  : the hit judge itself.
// Outputs of the judge: HitL/HitR return pulses, Serve/ServeDir launch,
// ScoreL/ScoreR, PointL/PointR pulses, GameOver/Winner, State (debug).
interface pong_hit_judge_if
    import pong_pkg::*;
#(
    parameter int unsigned LED_W = LED_W_DEF
);

    logic               Tick;
    logic [LED_W-1:0]   Ball;
    logic               BtnL;
    logic               BtnR;
    logic               Begin;

    logic               HitL;
    logic               HitR;
    logic               Serve;
    logic               ServeDir;
    logic [SCORE_W-1:0] ScoreL;
    logic [SCORE_W-1:0] ScoreR;
    logic               PointL;
    logic               PointR;
    logic               GameOver;
    logic               Winner;
    logic [1:0]         State;

    modport master (
        output Tick, Ball, BtnL, BtnR, Begin,
        input  HitL, HitR, Serve, ServeDir, ScoreL, ScoreR,
               PointL, PointR, GameOver, Winner, State
    );

    modport slave (
        input  Tick, Ball, BtnL, BtnR, Begin,
        output HitL, HitR, Serve, ServeDir, ScoreL, ScoreR,
               PointL, PointR, GameOver, Winner, State
    );

endinterface

// File: rtl/pong_score_counter.sv
// Per-player score counter: 4-bit, synchronous active-high reset,
// increments on inc and saturates at LIMIT.
//   clk, rst : clock and synchronous reset
//   inc      : point awarded this cycle
//   count    : current score
//   reach    : this increment brings the score to LIMIT (same cycle as inc)
module pong_score_counter
    import pong_pkg::*;
#(
    parameter logic [SCORE_W-1:0] LIMIT = SCORE_W'(WIN_SCORE_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [SCORE_W-1:0] count,
    output logic               reach
);

    localparam logic [SCORE_W-1:0] LAST = LIMIT - SCORE_W'(1);

    assign reach = inc && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count < LIMIT)) begin
            count <= count + SCORE_W'(1);
        end
    end

endmodule

// File: rtl/pong_hit_judge.sv
// Pong referee: decides hits and misses from the ball position and the
// players' button pulses, runs the serve/rally/game-over FSM and keeps the
// scores. All outputs are registered (one cycle after the deciding input).
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : slave side of pong_hit_judge_if
//              in : Tick, Ball (one-hot, MSB = left end), BtnL, BtnR, Begin
//              out: HitL, HitR, Serve, ServeDir, ScoreL, ScoreR,
//                   PointL, PointR, GameOver, Winner, State
module pong_hit_judge
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = WIN_SCORE_DEF,
    parameter int unsigned LED_W     = LED_W_DEF
) (
    input  logic            Clk,
    input  logic            Rst,
    pong_hit_judge_if.slave bus
);

    localparam logic [SCORE_W-1:0] WIN_LIMIT = SCORE_W'(WIN_SCORE);

    state_t state;
    state_t state_next;

    logic hitflag_l, hitflag_r;
    logic hitflag_l_d, hitflag_r_d;
    logic serve_hold;
    logic last_winner, last_winner_d;

    logic ball_ok, judging, at_left, at_right;
    logic hit_l, hit_r, miss_l, miss_r;
    logic win_l, win_r;
    logic serve_evt;

    logic hit_l_q, hit_r_q, point_l_q, point_r_q, serve_q, serve_dir_q;
    logic game_over_q, winner_q;
    logic serve_dir_d, game_over_d, winner_d;

    logic [SCORE_W-1:0] score_l, score_r;

    // ---------------------------------------------------------------
    // Hit / miss detection (only in RALLY with a clean one-hot ball)
    // ---------------------------------------------------------------
    always_comb begin
        ball_ok  = $onehot(bus.Ball);
        judging  = (state == RALLY) && ball_ok;
        at_left  = bus.Ball[LED_W-1];
        at_right = bus.Ball[0];

        hit_l  = judging && bus.BtnL && at_left  && !hitflag_l;
        hit_r  = judging && bus.BtnR && at_right && !hitflag_r;
        // A press landing on the same Tick wins over the miss.
        miss_l = judging && bus.Tick && at_left  && !hitflag_l && !hit_l;
        miss_r = judging && bus.Tick && at_right && !hitflag_r && !hit_r;
    end

    // Left player scores when the right end is missed, and vice versa.
    pong_score_counter #(.LIMIT(WIN_LIMIT)) u_score_l (
        .clk   (Clk),
        .rst   (Rst),
        .inc   (miss_r),
        .count (score_l),
        .reach (win_l)
    );

    pong_score_counter #(.LIMIT(WIN_LIMIT)) u_score_r (
        .clk   (Clk),
        .rst   (Rst),
        .inc   (miss_l),
        .count (score_r),
        .reach (win_r)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.Begin) state_next = RALLY;
            end
            RALLY: begin
                if (win_l || win_r)        state_next = OVER;
                else if (miss_l || miss_r) state_next = SERVE;
            end
            SERVE: begin
                if (bus.Begin && !serve_hold) state_next = RALLY;
            end
            OVER: begin
                state_next = OVER;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (next values of the registered outputs)
    // ---------------------------------------------------------------
    always_comb begin
        serve_evt     = 1'b0;
        serve_dir_d   = serve_dir_q;
        last_winner_d = last_winner;
        game_over_d   = game_over_q;
        winner_d      = winner_q;

        unique case (state)
            IDLE: begin
                if (bus.Begin) begin
                    serve_evt   = 1'b1;
                    serve_dir_d = DIR_RIGHT;
                end
            end
            RALLY: begin
                if (miss_r) last_winner_d = DIR_LEFT;
                if (miss_l) last_winner_d = DIR_RIGHT;
                if (win_l) begin
                    game_over_d = 1'b1;
                    winner_d    = DIR_LEFT;
                end
                if (win_r) begin
                    game_over_d = 1'b1;
                    winner_d    = DIR_RIGHT;
                end
            end
            SERVE: begin
                if (bus.Begin && !serve_hold) begin
                    serve_evt   = 1'b1;
                    serve_dir_d = last_winner;
                end
            end
            OVER: begin
            end
        endcase

        // Tick clears the flag after the miss check; a hit in that same
        // cycle re-arms it so a held button cannot score twice.
        hitflag_l_d = hitflag_l;
        hitflag_r_d = hitflag_r;
        if (bus.Tick) begin
            hitflag_l_d = 1'b0;
            hitflag_r_d = 1'b0;
        end
        if (hit_l) hitflag_l_d = 1'b1;
        if (hit_r) hitflag_r_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hit_l_q     <= 1'b0;
            hit_r_q     <= 1'b0;
            point_l_q   <= 1'b0;
            point_r_q   <= 1'b0;
            serve_q     <= 1'b0;
            serve_dir_q <= DIR_RIGHT;
            game_over_q <= 1'b0;
            winner_q    <= DIR_LEFT;
            hitflag_l   <= 1'b0;
            hitflag_r   <= 1'b0;
            last_winner <= DIR_RIGHT;
            serve_hold  <= 1'b1;
        end else begin
            hit_l_q     <= hit_l;
            hit_r_q     <= hit_r;
            point_l_q   <= miss_r;
            point_r_q   <= miss_l;
            serve_q     <= serve_evt;
            serve_dir_q <= serve_dir_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            hitflag_l   <= hitflag_l_d;
            hitflag_r   <= hitflag_r_d;
            last_winner <= last_winner_d;
            // High during the first cycle spent in SERVE, masking Begin.
            serve_hold  <= (state != SERVE);
        end
    end

    assign bus.HitL     = hit_l_q;
    assign bus.HitR     = hit_r_q;
    assign bus.PointL   = point_l_q;
    assign bus.PointR   = point_r_q;
    assign bus.Serve    = serve_q;
    assign bus.ServeDir = serve_dir_q;
    assign bus.GameOver = game_over_q;
    assign bus.Winner   = winner_q;
    assign bus.ScoreL   = score_l;
    assign bus.ScoreR   = score_r;
    assign bus.State    = state;

endmodule

// File: tb/tb_pong_hit_judge.sv
module tb_pong_hit_judge;

    typedef struct packed {
        logic       rst;
        logic       tick;
        logic       btnl;
        logic       btnr;
        logic       beg;
        logic [7:0] ball;
    } stim_t;

    typedef struct packed {
        logic       hit_l;
        logic       hit_r;
        logic       point_l;
        logic       point_r;
        logic       serve;
        logic       serve_dir;
        logic       game_over;
        logic       winner;
        logic [1:0] state;
        logic [3:0] score_l;
        logic [3:0] score_r;
    } obs_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RALLY = 2'd1;
    localparam logic [1:0] S_SERVE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int checks = 0;
    int fails  = 0;

    obs_t sb[$];

    pong_hit_judge_if #(.LED_W(8)) bus ();

    pong_hit_judge #(.WIN_SCORE(7), .LED_W(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    function automatic stim_t st(logic rst, logic tick, logic btnl, logic btnr,
                                 logic beg, logic [7:0] ball);
        return '{rst: rst, tick: tick, btnl: btnl, btnr: btnr, beg: beg, ball: ball};
    endfunction

    function automatic obs_t mk(logic hl, logic hr, logic pl, logic pr, logic sv,
                                logic sd, logic go, logic wn, logic [1:0] s,
                                logic [3:0] sl, logic [3:0] sr);
        return '{hit_l: hl, hit_r: hr, point_l: pl, point_r: pr, serve: sv,
                 serve_dir: sd, game_over: go, winner: wn, state: s,
                 score_l: sl, score_r: sr};
    endfunction

    function automatic obs_t sample();
        return '{hit_l: bus.HitL, hit_r: bus.HitR, point_l: bus.PointL,
                 point_r: bus.PointR, serve: bus.Serve, serve_dir: bus.ServeDir,
                 game_over: bus.GameOver, winner: bus.Winner, state: bus.State,
                 score_l: bus.ScoreL, score_r: bus.ScoreR};
    endfunction

    task automatic drive(stim_t s);
        Rst       = s.rst;
        bus.Tick  = s.tick;
        bus.BtnL  = s.btnl;
        bus.BtnR  = s.btnr;
        bus.Begin = s.beg;
        bus.Ball  = s.ball;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(st(1, 0, 0, 0, 0, 8'h00)); e.push_back(mk(0,0,0,0,0,1,0,0,S_IDLE,0,0));
        // Reset wins over a Begin/press/Tick in the same cycle.
        s.push_back(st(1, 1, 1, 1, 1, 8'h80)); e.push_back(mk(0,0,0,0,0,1,0,0,S_IDLE,0,0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_serve_hit();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,1,1,0,0,S_RALLY,0,0));
        s.push_back(st(0, 0, 0, 1, 0, 8'h01)); e.push_back(mk(0,1,0,0,0,1,0,0,S_RALLY,0,0));
        s.push_back(st(0, 0, 0, 1, 0, 8'h01)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,0));
        s.push_back(st(0, 1, 0, 0, 0, 8'h01)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,0));
        s.push_back(st(0, 0, 0, 1, 0, 8'h01)); e.push_back(mk(0,1,0,0,0,1,0,0,S_RALLY,0,0));
        s.push_back(st(0, 1, 0, 0, 0, 8'h02)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL serve_hit[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_miss();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(st(0, 1, 0, 0, 0, 8'h80)); e.push_back(mk(0,0,0,1,0,1,0,0,S_SERVE,0,1));
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,0,1,0,0,S_SERVE,0,1));
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,1,1,0,0,S_RALLY,0,1));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL miss[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_same_cycle();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(st(0, 1, 1, 0, 0, 8'h80)); e.push_back(mk(1,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 0, 1, 0, 0, 8'h80)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 1, 0, 0, 0, 8'h80)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 1, 0, 0, 0, 8'h40)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL same_cycle[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_ignored();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(st(0, 0, 1, 0, 0, 8'h10)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 1, 0, 0, 0, 8'h81)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 1, 0, 0, 0, 8'h00)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 0, 1, 1, 0, 8'h81)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 0, 1, 0, 0, 8'h01)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        s.push_back(st(0, 0, 0, 1, 0, 8'h80)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,1));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL ignored[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(st(0, 1, 0, 0, 0, 8'h80)); e.push_back(mk(0,0,0,1,0,1,0,0,S_SERVE,0,2));
        s.push_back(st(0, 0, 0, 0, 0, 8'h00)); e.push_back(mk(0,0,0,0,0,1,0,0,S_SERVE,0,2));
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,1,1,0,0,S_RALLY,0,2));
        s.push_back(st(0, 1, 0, 0, 0, 8'h80)); e.push_back(mk(0,0,0,1,0,1,0,0,S_SERVE,0,3));
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,0,1,0,0,S_SERVE,0,3));
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,1,1,0,0,S_RALLY,0,3));
        s.push_back(st(0, 0, 0, 0, 0, 8'h40)); e.push_back(mk(0,0,0,0,0,1,0,0,S_RALLY,0,3));
        s.push_back(st(1, 1, 1, 0, 1, 8'h80)); e.push_back(mk(0,0,0,0,0,1,0,0,S_IDLE,0,0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL mid_reset[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    // Seven back-to-back right-end misses: left wins, then OVER holds.
    task automatic test_game_end();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        logic  dir;
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,1,1,0,0,S_RALLY,0,0));
        dir = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            if (k < 7) begin
                s.push_back(st(0, 1, 0, 0, 0, 8'h01));
                e.push_back(mk(0,0,1,0,0,dir,0,0,S_SERVE,4'(k),0));
                s.push_back(st(0, 0, 0, 0, 1, 8'h00));
                e.push_back(mk(0,0,0,0,0,dir,0,0,S_SERVE,4'(k),0));
                dir = 1'b0;
                s.push_back(st(0, 0, 0, 0, 1, 8'h00));
                e.push_back(mk(0,0,0,0,1,dir,0,0,S_RALLY,4'(k),0));
            end else begin
                s.push_back(st(0, 1, 0, 0, 0, 8'h01));
                e.push_back(mk(0,0,1,0,0,dir,1,0,S_OVER,7,0));
            end
        end
        s.push_back(st(0, 0, 0, 0, 1, 8'h00)); e.push_back(mk(0,0,0,0,0,0,1,0,S_OVER,7,0));
        s.push_back(st(0, 1, 0, 0, 0, 8'h80)); e.push_back(mk(0,0,0,0,0,0,1,0,S_OVER,7,0));
        s.push_back(st(0, 0, 1, 0, 0, 8'h80)); e.push_back(mk(0,0,0,0,0,0,1,0,S_OVER,7,0));
        s.push_back(st(0, 0, 0, 1, 0, 8'h01)); e.push_back(mk(0,0,0,0,0,0,1,0,S_OVER,7,0));
        s.push_back(st(0, 1, 1, 1, 1, 8'h01)); e.push_back(mk(0,0,0,0,0,0,1,0,S_OVER,7,0));
        s.push_back(st(1, 0, 0, 0, 0, 8'h00)); e.push_back(mk(0,0,0,0,0,1,0,0,S_IDLE,0,0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(posedge Clk); #1;
            got  = sample();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL game_end[%0d]: got %p want %p", i, got, want);
            end
        end
    endtask

    initial begin
        drive(st(1, 0, 0, 0, 0, 8'h00));
        test_reset();
        test_serve_hit();
        test_miss();
        test_same_cycle();
        test_ignored();
        test_mid_reset();
        test_game_end();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish before", $time);
        $fatal(1);
    end

endmodule

// File: doc/pong_hit_judge.md
PONG_HIT_JUDGE -- requirements
Module: pong_hit_judge

Interface
REQ-001 Parameter WIN_SCORE, default 7, is the score that ends the game (1..15).
REQ-002 Parameter LED_W, default 8, is the ball-pattern width; bit LED_W-1 is the left end and bit 0 is the right end.
REQ-003 Clk  input  1  is the single system clock; all logic is rising-edge.
REQ-004 Rst  input  1  is a synchronous, active-high reset.
REQ-005 Tick  input  1  is a one-cycle pulse marking each ball step from the clock divider.
REQ-006 Ball  input  LED_W  is the LED pattern from the light pattern generator and is expected to be one-hot.
REQ-007 BtnL, BtnR  input  1 each  are synchronized one-cycle press pulses from the button synchronizers.
REQ-008 Begin  input  1  is the serve request, a level sampled each cycle.
REQ-009 HitL, HitR  output  1 each  are one-cycle return pulses that tell the generator to reverse.
REQ-010 Serve  output  1  is a one-cycle pulse that launches the ball; ServeDir  output  1  gives the launch direction (1 = toward the right).
REQ-011 ScoreL, ScoreR  output  4 each  are the player scores.
REQ-012 PointL, PointR  output  1 each  are one-cycle pulses, each marking a point awarded to that player.
REQ-013 GameOver  output  1  is a level flag; Winner  output  1  names the winner (0 = left, 1 = right) and is valid while GameOver is high.
REQ-014 State  output  2  exposes the FSM state for debug.

Function
REQ-015 FSM states: IDLE=0, RALLY=1, SERVE=2, OVER=3.
REQ-016 IDLE: Begin=1 -> Serve pulse with ServeDir=1, go to RALLY.
REQ-017 RALLY, left hit: BtnL=1 with Ball[LED_W-1]=1 and hitflagL=0 -> HitL=1 the next cycle, and hitflagL set.
REQ-018 RALLY, right hit: BtnR=1 with Ball[0]=1 and hitflagR=0 -> HitR=1 the next cycle, and hitflagR set.
REQ-019 Registered-output latency is 1 cycle for HitL/HitR, PointL/PointR, Serve and the score update.
REQ-020 A button press while the ball is not at that player's end is ignored; there is no foul and no state change.
REQ-021 A second press while that player's hitflag is set is ignored.
REQ-022 Both hitflags clear on every Tick, after the miss evaluation in REQ-023 has been made.
REQ-023 RALLY miss: Tick=1 with Ball[LED_W-1]=1 and hitflagL=0 -> PointR pulse, ScoreR+1, go to SERVE; the mirror case for the right end gives PointL.
REQ-024 A press and a Tick in the same cycle at the same end count as a hit, not a miss.
REQ-025 BtnL and BtnR are evaluated independently; both may act in the same cycle.
REQ-026 If Ball is not one-hot (zero bits or more than one bit set), hit and miss detection is suppressed for that cycle.
REQ-027 SERVE: Begin=1 -> Serve pulse with ServeDir toward the player who won the last point, go to RALLY; Begin is ignored for 1 cycle after entering SERVE.
REQ-028 When a score update makes a score equal WIN_SCORE -> go to OVER, GameOver=1, and Winner latched, all in the same cycle as the score update.
REQ-029 OVER is terminal: all button, Tick and Begin inputs are ignored, scores hold, and the state is left only by Rst.
REQ-030 Scores saturate at WIN_SCORE and never wrap.
REQ-031 The pulse outputs are never high for more than 1 consecutive cycle.

Reset
REQ-032 Rst takes priority over every other input; it is applied on the next rising edge, including mid-rally or in OVER.
REQ-033 Reset values: State=IDLE, ScoreL=ScoreR=0, both hitflags=0, all pulses=0, GameOver=0, Winner=0, ServeDir=1.

Structure
REQ-034 The shared package pong_pkg holds the state encodings, WIN_SCORE and LED_W defaults, and the direction constants (DIR_LEFT=0, DIR_RIGHT=1).
REQ-035 One sub-module, pong_score_counter (4-bit, increment-enable, saturate at limit, sync reset), is instantiated once per player.
REQ-036 The FSM, the hit/miss detection and the hitflags live in pong_hit_judge itself.

Verification
REQ-037 Serve and hit: Rst, Begin=1 -> Serve=1 with ServeDir=1 one cycle later; Ball=8'b0000_0001 with BtnR -> HitR=1 the next cycle and ScoreL/ScoreR unchanged.
REQ-038 Miss: Ball=8'b1000_0000, Tick with no BtnL -> PointR=1, ScoreR=1, State=SERVE; Begin after 2 cycles -> ServeDir=1.
REQ-039 Same-cycle boundary: BtnL and Tick together with Ball=8'b1000_0000 -> HitL=1 and no point; BtnL again in the next cycle -> no second HitL.
REQ-040 Ignored inputs: BtnL with Ball=8'b0001_0000 -> no output change; Ball=8'b1000_0001 with Tick -> no point.
REQ-041 Game end: 7 right-side misses -> ScoreL=7, GameOver=1, Winner=0; further Begin/Btn/Tick inputs -> no change.
REQ-042 Mid-operation reset: Rst asserted in RALLY with ScoreR=3 -> on the next edge all outputs hold their REQ-033 values.
